// File: rtl/aes_pkg.sv
// Shared AES key-schedule definitions: round count, FSM state encoding, round constants.
package aes_pkg;

   localparam int NUM_ROUNDS = 10;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_EXPAND = 2'd1,
      ST_EMIT   = 2'd2
   } state_e;

   // Round constant placed in the top byte; indices outside 0..9 yield zero.
   function automatic logic [31:0] rcon(input logic [3:0] idx);
      logic [7:0] rc;
      case (idx)
         4'd0:    rc = 8'h01;
         4'd1:    rc = 8'h02;
         4'd2:    rc = 8'h04;
         4'd3:    rc = 8'h08;
         4'd4:    rc = 8'h10;
         4'd5:    rc = 8'h20;
         4'd6:    rc = 8'h40;
         4'd7:    rc = 8'h80;
         4'd8:    rc = 8'h1b;
         4'd9:    rc = 8'h36;
         default: rc = 8'h00;
      endcase
      return {rc, 24'h000000};
   endfunction

endpackage

// File: rtl/inv_key_schedule_if.sv
// Key-in / round-key-out handshake bundle for the inverse key schedule.
interface inv_key_schedule_if;
   logic         key_valid;
   logic         key_ready;
   logic [127:0] cipher_key;
   logic         rk_valid;
   logic         rk_ready;
   logic [127:0] round_key;
   logic [3:0]   rk_round;
   logic         rk_last;

   modport master (
      output key_valid, cipher_key, rk_ready,
      input  key_ready, rk_valid, round_key, rk_round, rk_last
   );

   modport slave (
      input  key_valid, cipher_key, rk_ready,
      output key_ready, rk_valid, round_key, rk_round, rk_last
   );
endinterface

// File: rtl/S_box.sv
// AES forward S-box: GF(2^8) inverse (x^254) followed by the affine transform.
module S_box (
   input  logic [7:0] in_i,
   output logic [7:0] out_o
);

   function automatic logic [7:0] xtime(input logic [7:0] a);
      return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
   endfunction

   function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p;
      logic [7:0] aa;
      p  = 8'h00;
      aa = a;
      for (int i = 0; i < 8; i++) begin
         if (b[i]) p = p ^ aa;
         aa = xtime(aa);
      end
      return p;
   endfunction

   logic [7:0] inv;

   // Square-and-multiply for x^(2+4+...+128) = x^254; zero maps to zero.
   always_comb begin
      logic [7:0] pw;
      inv = 8'h01;
      pw  = in_i;
      for (int i = 1; i < 8; i++) begin
         pw  = gf_mul(pw, pw);
         inv = gf_mul(inv, pw);
      end
   end

   assign out_o = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]}
                      ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;

endmodule

// File: rtl/sub_word.sv
// SubWord: byte-wise S-box over a 32-bit word.
module sub_word (
   input  logic [31:0] word_i,
   output logic [31:0] word_o
);

   for (genvar g = 0; g < 4; g++) begin : g_sbox
      S_box u_sbox (
         .in_i  (word_i[8*g +: 8]),
         .out_o (word_o[8*g +: 8])
      );
   end

endmodule

// File: rtl/inv_key_schedule.sv
// AES-128 inverse key schedule: expands the cipher key forward to round 10,
// then walks back emitting round keys 10..0 over a valid/ready stream.
module inv_key_schedule
   import aes_pkg::*;
(
   input  logic                 clk,
   input  logic                 rst,
   inv_key_schedule_if.slave    bus
);

   state_e       state_q, state_d;
   logic [127:0] wk_q, wk_d;
   logic [3:0]   cnt_q, cnt_d;

   logic [31:0]  w0, w1, w2, w3;
   logic [31:0]  sw_src, sw_in, sw_out;
   logic [31:0]  f0, f1, f2, f3;
   logic [31:0]  i0, i1, i2, i3;
   logic         rk_hs;

   assign {w0, w1, w2, w3} = wk_q;

   // Forward step rotates w3; inverse step needs the recovered w3 (w3^w2).
   assign sw_src = (state_q == ST_EMIT) ? (w3 ^ w2) : w3;
   assign sw_in  = {sw_src[23:0], sw_src[31:24]};

   sub_word u_sub_word (
      .word_i (sw_in),
      .word_o (sw_out)
   );

   assign f0 = w0 ^ sw_out ^ rcon(cnt_q);
   assign f1 = f0 ^ w1;
   assign f2 = f1 ^ w2;
   assign f3 = f2 ^ w3;

   assign i3 = w3 ^ w2;
   assign i2 = w2 ^ w1;
   assign i1 = w1 ^ w0;
   assign i0 = w0 ^ sw_out ^ rcon(cnt_q - 4'd1);

   assign rk_hs = (state_q == ST_EMIT) && bus.rk_ready;

   // State, working key and round counter; reset wins over any handshake.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_IDLE;
         wk_q    <= '0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         wk_q    <= wk_d;
         cnt_q   <= cnt_d;
      end
   end

   // Next state plus the key/counter update belonging to each transition.
   always_comb begin
      state_d = state_q;
      wk_d    = wk_q;
      cnt_d   = cnt_q;
      case (state_q)
         ST_IDLE: begin
            if (bus.key_valid) begin
               state_d = ST_EXPAND;
               wk_d    = bus.cipher_key;
               cnt_d   = 4'd0;
            end
         end
         ST_EXPAND: begin
            wk_d = {f0, f1, f2, f3};
            if (cnt_q == 4'(NUM_ROUNDS - 1)) begin
               state_d = ST_EMIT;
               cnt_d   = 4'(NUM_ROUNDS);
            end else begin
               cnt_d = cnt_q + 4'd1;
            end
         end
         ST_EMIT: begin
            if (rk_hs) begin
               if (cnt_q == 4'd0) begin
                  state_d = ST_IDLE;
                  wk_d    = '0;
               end else begin
                  wk_d  = {i0, i1, i2, i3};
                  cnt_d = cnt_q - 4'd1;
               end
            end
         end
         default: begin
            state_d = ST_IDLE;
            wk_d    = '0;
            cnt_d   = '0;
         end
      endcase
   end

   // Outputs are pure functions of state; the stream is zeroed outside EMIT.
   always_comb begin
      bus.key_ready = (state_q == ST_IDLE);
      bus.rk_valid  = (state_q == ST_EMIT);
      bus.round_key = (state_q == ST_EMIT) ? wk_q : '0;
      bus.rk_round  = (state_q == ST_EMIT) ? cnt_q : 4'd0;
      bus.rk_last   = (state_q == ST_EMIT) && (cnt_q == 4'd0);
   end

endmodule

// File: doc/inv_key_schedule.md
INV_KEY_SCHEDULE -- requirements
Module: inv_key_schedule

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset; all state SHALL update on the rising edge of clk.
REQ-002 clk  in  1  system clock.
REQ-003 rst  in  1  synchronous active-high reset.
REQ-004 key_valid  in  1  cipher_key is valid.
REQ-005 key_ready  out  1  block accepts a new cipher key.
REQ-006 cipher_key  in  128  AES-128 cipher key; word w0 is [127:96] and w3 is [31:0].
REQ-007 rk_valid  out  1  round_key and rk_round are valid.
REQ-008 rk_ready  in  1  consumer accepts the current round key.
REQ-009 round_key  out  128  decryption-order round key, same word layout as cipher_key.
REQ-010 rk_round  out  4  round index of round_key, 10 down to 0.
REQ-011 rk_last  out  1  high with rk_valid when rk_round==0.

Function
REQ-012 The state machine SHALL have three states: IDLE, EXPAND and EMIT.
REQ-013 key_ready SHALL equal (state==IDLE); a key SHALL be accepted on a cycle where key_valid and key_ready are both high, loading cipher_key into a 128-bit working register and setting the round counter to 0.
REQ-014 EXPAND SHALL apply one forward step per cycle for 10 cycles:
- w0' = w0 ^ SubWord(RotWord(w3)) ^ rcon(cnt), with cnt 0..9.
- w1' = w0' ^ w1; w2' = w1' ^ w2; w3' = w2' ^ w3.
REQ-015 After the 10th EXPAND cycle, the block SHALL enter EMIT with the round-10 key in the working register and rk_round=10; rk_valid SHALL first be high 11 cycles after the acceptance edge.
REQ-016 In EMIT, rk_valid SHALL be 1; round_key, rk_round and rk_last SHALL be held stable while rk_valid && !rk_ready.
REQ-017 On a handshake (rk_valid && rk_ready) with rk_round=r>0, the next cycle SHALL present round r-1 via one inverse step:
- w3' = w3 ^ w2; w2' = w2 ^ w1; w1' = w1 ^ w0.
- w0' = w0 ^ SubWord(RotWord(w3')) ^ rcon(r-1).
REQ-018 On a handshake with rk_round=0, the block SHALL return to IDLE; rk_valid SHALL be 0 and key_ready SHALL be 1 on the next cycle.
REQ-019 RotWord SHALL be a left byte rotation {w[23:0],w[31:24]}; rcon(i) for i=0..9 SHALL be 01,02,04,08,10,20,40,80,1b,36 in bits [31:24], with zero in all other bits and for any other index.
REQ-020 key_valid SHALL be ignored outside IDLE, and cipher_key SHALL NOT affect an operation in progress.
REQ-021 rk_ready SHALL be ignored when rk_valid=0.
REQ-022 rk_valid, rk_round and rk_last SHALL be 0 in IDLE and EXPAND; round_key SHALL be 0 in those states.
REQ-023 The block SHALL NOT assert rk_valid and key_ready in the same cycle.
REQ-024 The block SHALL emit exactly 11 round keys per accepted key, in order 10..0; the round-0 key SHALL equal the accepted cipher_key.

Reset
REQ-025 When rst=1 at a clock edge, the next state SHALL be IDLE, the working register and counter SHALL be 0, rk_valid/rk_last/rk_round/round_key SHALL be 0 and key_ready SHALL be 1, regardless of current state; this includes mid-EXPAND and mid-EMIT.
REQ-026 rst SHALL take priority over any simultaneous handshake.

Structure
REQ-027 The shared package aes_pkg SHALL hold the rcon table/function, NUM_ROUNDS=10 and the state enum typedef.
REQ-028 One sub-module, sub_word (32-bit input, 32-bit output, four instances of the existing S_box), SHALL be instantiated once.
REQ-029 The sub_word input SHALL be muxed between RotWord(w3) in EXPAND and RotWord(w3^w2) in EMIT.

Verification
REQ-030 Scenario 1: cipher_key=2b7e151628aed2a6abf7158809cf4f3c, rk_ready=1 -> rk_valid rises 11 cycles after acceptance; round 10 = d014f9a8c9ee2589e13f0cc8b6630ca6; round 1 = a0fafe1788542cb123a339392a6c7605; round 0 = cipher_key with rk_last=1; key_ready high the following cycle.
REQ-031 Scenario 2: cipher_key=0, rk_ready=1 -> round 10 = b4ef5bcb3e92e21123e951cf6f8f188e; round 1 = 62636363626363636263636362636363; round 0 = 0.
REQ-032 Scenario 3: Scenario 1 key with rk_ready toggled pseudo-randomly -> same 11 keys in the same order, each held stable while stalled, with no duplicates or drops.
REQ-033 Scenario 4: rst pulsed at EXPAND cycle 5, and separately after round 6 is emitted -> IDLE next cycle with all outputs 0 and key_ready=1; a fresh key then produces the full correct sequence.
REQ-034 Scenario 5: key_valid held high with a changing cipher_key during EXPAND/EMIT -> ignored and the sequence is unchanged; a key presented in the cycle after the rk_last handshake is accepted immediately, giving back-to-back operation.
